packet_gate: RTL and testbench



---
 rtl/packet_gate.sv | 183 ++++++++++++++++++
 tb/tb_packet_gate.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_gate.sv
// Packet gate: buffers AXI-Stream beats and forwards or discards each packet according to one
// verdict popped per packet. Define PACKET_GATE_COUNTERS_EN to get forwarded/dropped packet counters.
module packet_gate #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DATA_FIFO_DEPTH_BITS = 5
) (
    input  logic                              axi_aclk,
    input  logic                              reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,

    input  logic                              result_dout,
    input  logic                              result_empty,
    output logic                              result_rd_en,

    output logic [31:0]                       pkt_fwd_count,
    output logic [31:0]                       pkt_drop_count
);

    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int SW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int EW    = 1 + UW + SW + DW;
    localparam int DEPTH = 1 << DATA_FIFO_DEPTH_BITS;

    // Back-pressure one entry early so the registered write never overruns the array.
    localparam logic [DATA_FIFO_DEPTH_BITS:0] NEARLY_FULL_LEVEL =
        (DATA_FIFO_DEPTH_BITS + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        WAIT_VERDICT = 2'd0,
        FORWARD      = 2'd1,
        DROP         = 2'd2
    } state_t;

    state_t state, state_next;

    logic [EW-1:0]                   mem [DEPTH];
    logic [DATA_FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [DATA_FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [DATA_FIFO_DEPTH_BITS:0]   count;
    logic [EW-1:0]                   head;
    logic                            head_tlast;
    logic                            fifo_empty;
    logic                            fifo_nearly_full;
    logic                            fifo_wr;
    logic                            fifo_pop;
    logic                            fwd_valid;

    assign fifo_empty       = (count == '0);
    assign fifo_nearly_full = (count >= NEARLY_FULL_LEVEL);
    assign s_axis_tready    = ~fifo_nearly_full;
    assign fifo_wr          = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge axi_aclk) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Fallthrough read: the head entry drives the master side combinationally.
    assign head       = mem[rd_ptr];
    assign head_tlast = head[EW-1];

    assign m_axis_tdata  = head[DW-1:0];
    assign m_axis_tstrb  = head[DW+SW-1:DW];
    assign m_axis_tuser  = head[DW+SW+UW-1:DW+SW];
    assign m_axis_tlast  = head_tlast & fwd_valid;
    assign m_axis_tvalid = fwd_valid;

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state <= WAIT_VERDICT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_VERDICT: begin
                if (!result_empty) begin
                    state_next = result_dout ? FORWARD : DROP;
                end
            end
            FORWARD, DROP: begin
                if (fifo_pop && head_tlast) begin
                    state_next = WAIT_VERDICT;
                end
            end
            default: state_next = WAIT_VERDICT;
        endcase
    end

    always_comb begin
        result_rd_en = 1'b0;
        fwd_valid    = 1'b0;
        fifo_pop     = 1'b0;
        case (state)
            WAIT_VERDICT: begin
                // Verdict is taken even if no beat has arrived yet.
                result_rd_en = ~result_empty & ~reset;
            end
            FORWARD: begin
                fwd_valid = ~fifo_empty;
                fifo_pop  = ~fifo_empty & m_axis_tready;
            end
            DROP: begin
                fifo_pop = ~fifo_empty;
            end
            default: begin
                result_rd_en = 1'b0;
            end
        endcase
    end

`ifdef PACKET_GATE_COUNTERS_EN
    logic [31:0] fwd_cnt;
    logic [31:0] drop_cnt;
    logic        fwd_done;
    logic        drop_done;

    assign fwd_done  = (state == FORWARD) & fifo_pop & head_tlast;
    assign drop_done = (state == DROP) & fifo_pop & head_tlast;

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            fwd_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (fwd_done && (fwd_cnt != 32'hFFFF_FFFF)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
            if (drop_done && (drop_cnt != 32'hFFFF_FFFF)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    assign pkt_fwd_count  = fwd_cnt;
    assign pkt_drop_count = drop_cnt;
`else
    assign pkt_fwd_count  = 32'h0;
    assign pkt_drop_count = 32'h0;
`endif

endmodule

// File: tb/tb_packet_gate.sv
// Directed bench for packet_gate: models the result FIFO and upstream source, scoreboards output beats.
module tb_packet_gate;

`ifdef PACKET_GATE_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic         last;
        logic [127:0] user;
        logic [31:0]  strb;
        logic [255:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic         result_dout;
    logic         result_empty;
    logic         result_rd_en;
    logic [31:0]  pkt_fwd_count;
    logic [31:0]  pkt_drop_count;

    packet_gate dut (
        .axi_aclk       (clk),
        .reset          (reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tstrb   (s_axis_tstrb),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tstrb   (m_axis_tstrb),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .result_dout    (result_dout),
        .result_empty   (result_empty),
        .result_rd_en   (result_rd_en),
        .pkt_fwd_count  (pkt_fwd_count),
        .pkt_drop_count (pkt_drop_count)
    );

    always #5 clk = ~clk;

    beat_t m_beat;
    assign m_beat = {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata};

    beat_t send_q[$];
    beat_t out_q[$];
    beat_t exp_q[$];
    bit    vq[$];
    int    out_cyc[$];

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    rd_cnt = 0;
    int    acc_cnt = 0;
    int    exp_fwd = 0;
    int    exp_drop = 0;
    bit    saw_mvalid = 1'b0;
    bit    toggle_mode = 1'b0;
    bit    stalled = 1'b0;
    beat_t stall_beat;
    int    rd0;
    int    acc0;

    function automatic beat_t mk_beat(input int id, input bit last);
        beat_t b;
        b.data = {8{32'(id) ^ 32'hA5A5_0000}};
        b.user = {4{~32'(id)}};
        b.strb = 32'(id) * 32'd3 + 32'd1;
        b.last = last;
        return b;
    endfunction

    function automatic logic [31:0] cexp(input int v);
        return CNT_EN ? 32'(v) : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        s_axis_tvalid = (send_q.size() > 0);
        if (send_q.size() > 0) begin
            s_axis_tdata = send_q[0].data;
            s_axis_tstrb = send_q[0].strb;
            s_axis_tuser = send_q[0].user;
            s_axis_tlast = send_q[0].last;
        end else begin
            s_axis_tdata = '0;
            s_axis_tstrb = '0;
            s_axis_tuser = '0;
            s_axis_tlast = 1'b0;
        end
        result_empty = (vq.size() == 0);
        result_dout  = (vq.size() > 0) ? vq[0] : 1'b0;
    endtask

    // One clock: sample handshakes at negedge, advance, then update drivers after the edge.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            if (s_axis_tvalid && s_axis_tready) begin
                void'(send_q.pop_front());
                acc_cnt++;
            end
            if (m_axis_tvalid) saw_mvalid = 1'b1;
            if (stalled) chk("hold_stable", {m_axis_tvalid, 512'(m_beat)}, {1'b1, 512'(stall_beat)});
            stalled    = m_axis_tvalid && !m_axis_tready;
            stall_beat = m_beat;
            if (m_axis_tvalid && m_axis_tready) begin
                out_q.push_back(m_beat);
                out_cyc.push_back(cyc);
            end
            if (result_rd_en) begin
                rd_cnt++;
                if (vq.size() > 0) void'(vq.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (toggle_mode) m_axis_tready = ~m_axis_tready;
        drive();
    endtask

    task automatic run_until_out(input string tag, input int n, input int budget);
        int b;
        b = 0;
        while (out_q.size() < n && b < budget) begin
            tick();
            b++;
        end
        chk({tag, "_beats_seen"}, 512'(out_q.size()), 512'(n));
    endtask

    task automatic cmp_out(input string tag);
        chk({tag, "_count"}, 512'(out_q.size()), 512'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_beat"}, 512'(out_q[i]), 512'(exp_q[i]));
        end
        out_q.delete();
        exp_q.delete();
        out_cyc.delete();
    endtask

    task automatic send_pkt(input int first_id, input int nbeats, input bit expect_out);
        for (int i = 0; i < nbeats; i++) begin
            send_q.push_back(mk_beat(first_id + i, i == nbeats - 1));
            if (expect_out) exp_q.push_back(mk_beat(first_id + i, i == nbeats - 1));
        end
    endtask

    initial begin
        reset         = 1'b1;
        m_axis_tready = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #3;
        chk("rst_m_tvalid", 512'(m_axis_tvalid), 512'(0));
        chk("rst_m_tlast", 512'(m_axis_tlast), 512'(0));
        chk("rst_rd_en", 512'(result_rd_en), 512'(0));
        chk("rst_fwd_cnt", 512'(pkt_fwd_count), 512'(0));
        chk("rst_drop_cnt", 512'(pkt_drop_count), 512'(0));
        chk("rst_s_tready", 512'(s_axis_tready), 512'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive();

        // Forward a 3-beat packet.
        m_axis_tready = 1'b1;
        rd0 = rd_cnt;
        vq.push_back(1'b1);
        send_pkt(1, 3, 1'b1);
        drive();
        run_until_out("fwd3", 3, 50);
        repeat (3) tick();
        cmp_out("fwd3");
        chk("fwd3_rd_pulses", 512'(rd_cnt - rd0), 512'(1));
        exp_fwd = 1;
        chk("fwd3_fwd_cnt", 512'(pkt_fwd_count), 512'(cexp(exp_fwd)));

        // Drop a 4-beat packet.
        saw_mvalid = 1'b0;
        acc0 = acc_cnt;
        vq.push_back(1'b0);
        send_pkt(10, 4, 1'b0);
        drive();
        repeat (12) tick();
        chk("drop4_accepted", 512'(acc_cnt - acc0), 512'(4));
        chk("drop4_no_mvalid", 512'(saw_mvalid), 512'(0));
        exp_drop = 1;
        chk("drop4_drop_cnt", 512'(pkt_drop_count), 512'(cexp(exp_drop)));
        chk("drop4_fwd_cnt", 512'(pkt_fwd_count), 512'(cexp(exp_fwd)));

        // Verdicts 1,0,1 on single-beat packets A,B,C.
        vq.push_back(1'b1);
        vq.push_back(1'b0);
        vq.push_back(1'b1);
        send_pkt(20, 1, 1'b1);
        send_pkt(21, 1, 1'b0);
        send_pkt(22, 1, 1'b1);
        drive();
        run_until_out("abc", 2, 60);
        repeat (4) tick();
        if (out_cyc.size() >= 2) chk("abc_spacing", 512'(out_cyc[1] - out_cyc[0]), 512'(4));
        cmp_out("abc");
        exp_fwd  = 3;
        exp_drop = 2;
        chk("abc_fwd_cnt", 512'(pkt_fwd_count), 512'(cexp(exp_fwd)));
        chk("abc_drop_cnt", 512'(pkt_drop_count), 512'(cexp(exp_drop)));

        // Toggling m_axis_tready; beats must hold while stalled.
        m_axis_tready = 1'b0;
        toggle_mode   = 1'b1;
        vq.push_back(1'b1);
        send_pkt(30, 2, 1'b1);
        drive();
        run_until_out("toggle", 2, 40);
        toggle_mode   = 1'b0;
        m_axis_tready = 1'b1;
        repeat (4) tick();
        cmp_out("toggle");
        exp_fwd = 4;
        chk("toggle_fwd_cnt", 512'(pkt_fwd_count), 512'(cexp(exp_fwd)));

        // Fill with no verdict and no sink, then release a 40-beat packet.
        m_axis_tready = 1'b0;
        acc0 = acc_cnt;
        rd0  = rd_cnt;
        send_pkt(100, 40, 1'b1);
        drive();
        repeat (45) tick();
        chk("fill_accepted", 512'(acc_cnt - acc0), 512'(31));
        chk("fill_s_tready", 512'(s_axis_tready), 512'(0));
        chk("fill_m_tvalid", 512'(m_axis_tvalid), 512'(0));
        chk("fill_no_rd", 512'(rd_cnt - rd0), 512'(0));
        vq.push_back(1'b1);
        m_axis_tready = 1'b1;
        drive();
        run_until_out("fill", 40, 200);
        repeat (3) tick();
        cmp_out("fill");
        exp_fwd = 5;
        chk("fill_fwd_cnt", 512'(pkt_fwd_count), 512'(cexp(exp_fwd)));

        // Reset in the middle of a 5-beat forwarded packet.
        vq.push_back(1'b1);
        send_pkt(200, 5, 1'b0);
        drive();
        run_until_out("midrst", 2, 40);
        reset = 1'b1;
        send_q.delete();
        vq.delete();
        drive();
        tick();
        #2;
        chk("midrst_m_tvalid", 512'(m_axis_tvalid), 512'(0));
        chk("midrst_rd_en", 512'(result_rd_en), 512'(0));
        chk("midrst_fwd_cnt", 512'(pkt_fwd_count), 512'(0));
        chk("midrst_drop_cnt", 512'(pkt_drop_count), 512'(0));
        reset = 1'b0;
        out_q.delete();
        exp_q.delete();
        out_cyc.delete();
        stalled = 1'b0;
        vq.push_back(1'b1);
        send_pkt(210, 3, 1'b1);
        drive();
        run_until_out("postrst", 3, 50);
        repeat (3) tick();
        cmp_out("postrst");
        chk("postrst_fwd_cnt", 512'(pkt_fwd_count), 512'(cexp(1)));
        chk("postrst_drop_cnt", 512'(pkt_drop_count), 512'(cexp(0)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
